// File: rtl/fwd_track.sv
// rtl/fwd_track.sv - EX-operand forwarding select and load-use stall tracking
module fwd_track #(
   parameter int RAW = 5,
   parameter int CW  = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           stall_i,
   input  logic           flush_i,
   input  logic           id_valid_i,
   input  logic [RAW-1:0] id_rs_i,
   input  logic [RAW-1:0] id_rt_i,
   input  logic [RAW-1:0] id_rd_i,
   input  logic           id_regwrite_i,
   input  logic           id_memread_i,
   output logic [1:0]     fwd_a_o,
   output logic [1:0]     fwd_b_o,
   output logic           lu_stall_o,
   output logic [CW-1:0]  lu_cnt_o
);

   logic           ex_valid_q, ex_regwrite_q, ex_memread_q;
   logic [RAW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
   logic           mem_valid_q, mem_regwrite_q, mem_memread_q;
   logic [RAW-1:0] mem_rd_q;
   logic           wb_valid_q, wb_regwrite_q;
   logic [RAW-1:0] wb_rd_q;
   logic [CW-1:0]  lu_cnt_q, lu_cnt_d;
   logic           bubble;

   // MEM is checked first so the youngest producer wins; r0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src);
      if (ex_valid_q && mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == src))
         return 2'b10;
      else if (ex_valid_q && wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwd_a_o = fwd_sel(ex_rs_q);
   assign fwd_b_o = fwd_sel(ex_rt_q);

   assign lu_stall_o = id_valid_i && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                       ((ex_rd_q == id_rs_i) || (ex_rd_q == id_rt_i));

   assign bubble   = flush_i || lu_stall_o;
   assign lu_cnt_o = lu_cnt_q;

   always_comb begin
      lu_cnt_d = lu_cnt_q;
      if (!stall_i && lu_stall_o && !flush_i && (lu_cnt_q != {CW{1'b1}}))
         lu_cnt_d = lu_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_q     <= 1'b0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= '0;
         wb_regwrite_q  <= 1'b0;
         lu_cnt_q       <= '0;
      end else if (!stall_i) begin
         wb_valid_q     <= mem_valid_q;
         wb_rd_q        <= mem_rd_q;
         wb_regwrite_q  <= mem_regwrite_q;
         mem_valid_q    <= ex_valid_q;
         mem_rd_q       <= ex_rd_q;
         mem_regwrite_q <= ex_regwrite_q;
         mem_memread_q  <= ex_memread_q;
         lu_cnt_q       <= lu_cnt_d;
         if (bubble) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
         end else begin
            ex_valid_q    <= id_valid_i;
            ex_rs_q       <= id_rs_i;
            ex_rt_q       <= id_rt_i;
            ex_rd_q       <= id_rd_i;
            ex_regwrite_q <= id_regwrite_i;
            ex_memread_q  <= id_memread_i;
         end
      end
   end

endmodule

// File: tb/tb_fwd_track.sv
// tb/tb_fwd_track.sv - directed self-checking bench for fwd_track (CW=4)
module tb_fwd_track;

   localparam int RAW = 5;
   localparam int CW  = 4;

   logic           clk_i = 1'b0;
   logic           rst_i, stall_i, flush_i;
   logic           id_valid_i, id_regwrite_i, id_memread_i;
   logic [RAW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [1:0]     fwd_a_o, fwd_b_o;
   logic           lu_stall_o;
   logic [CW-1:0]  lu_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   fwd_track #(.RAW(RAW), .CW(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .lu_stall_o(lu_stall_o), .lu_cnt_o(lu_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // A load sitting in MEM must never be selected as a forwarding source.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         n_checks++;
         if ((fwd_a_o == 2'b10 || fwd_b_o == 2'b10) && dut.mem_memread_q) begin
            n_fail++;
            $display("FAIL mem_load_fwd: fwd_a=%b fwd_b=%b with MEM.memread=1, required no 10 code", fwd_a_o, fwd_b_o);
         end
      end
   end

   task automatic id(input logic v, input int rs, input int rt, input int rd, input logic rw, input logic mr);
      id_valid_i = v; id_rs_i = RAW'(rs); id_rt_i = RAW'(rt); id_rd_i = RAW'(rd);
      id_regwrite_i = rw; id_memread_i = mr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   task automatic drain();
      id(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         id(1'b1, $urandom_range(31), $urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom));
         tick();
      end
      id(1'b1, $urandom_range(31), $urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom));
      n_checks++; if (fwd_a_o !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_o); end
      n_checks++; if (fwd_b_o !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b_o); end
      n_checks++; if (lu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_lu_stall: got %b want 0", lu_stall_o); end
      n_checks++; if (lu_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_lu_cnt: got %0d want 0", lu_cnt_o); end
      rst_i = 1'b0;
      id(1, 1, 2, 7, 1, 1);
      tick();
      id(1, 7, 0, 9, 1, 0);
      n_checks++; if (lu_stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_first_load: lu_stall got %b want 1", lu_stall_o); end
      id(0, 7, 0, 9, 1, 0);
      n_checks++; if (lu_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_idvalid_gate: lu_stall got %b want 0", lu_stall_o); end
      drain();
   endtask

   task automatic test_back_to_back();
      id(1, 1, 2, 3, 1, 0); tick();
      id(1, 3, 3, 6, 1, 0); tick();
      n_checks++; if (fwd_a_o !== 2'b10) begin n_fail++; $display("FAIL b2b_fwd_a: got %b want 10", fwd_a_o); end
      n_checks++; if (fwd_b_o !== 2'b10) begin n_fail++; $display("FAIL b2b_fwd_b: got %b want 10", fwd_b_o); end
      id(1, 3, 0, 8, 1, 0); tick();
      n_checks++; if (fwd_a_o !== 2'b01) begin n_fail++; $display("FAIL b2b_wb_fwd_a: got %b want 01", fwd_a_o); end
      n_checks++; if (fwd_b_o !== 2'b00) begin n_fail++; $display("FAIL b2b_r0_fwd_b: got %b want 00", fwd_b_o); end
      drain();
   endtask

   task automatic test_double_producer();
      id(1, 0, 0, 4, 1, 0); tick();
      id(1, 0, 0, 4, 1, 0); tick();
      id(1, 4, 9, 10, 1, 0); tick();
      n_checks++; if (fwd_a_o !== 2'b10) begin n_fail++; $display("FAIL dbl_mem_wins: got %b want 10", fwd_a_o); end
      n_checks++; if (fwd_b_o !== 2'b00) begin n_fail++; $display("FAIL dbl_fwd_b: got %b want 00", fwd_b_o); end
      drain();
      id(1, 0, 0, 0, 1, 0); tick();
      id(1, 0, 0, 0, 1, 0); tick();
      id(1, 0, 0, 5, 1, 0); tick();
      n_checks++; if (fwd_a_o !== 2'b00) begin n_fail++; $display("FAIL r0_fwd_a: got %b want 00", fwd_a_o); end
      n_checks++; if (fwd_b_o !== 2'b00) begin n_fail++; $display("FAIL r0_fwd_b: got %b want 00", fwd_b_o); end
      drain();
   endtask

   task automatic test_load_use();
      id(1, 1, 0, 5, 1, 1); tick();
      id(1, 2, 5, 11, 1, 0);
      n_checks++; if (lu_stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_raise: got %b want 1", lu_stall_o); end
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++; if (lu_stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0", lu_stall_o); end
      n_checks++; if (fwd_b_o !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_fwd_b: got %b want 00", fwd_b_o); end
      n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL lu_cnt_inc: got %0d want %0d", lu_cnt_o, exp_cnt); end
      tick();
      id(0, 0, 0, 0, 0, 0);
      n_checks++; if (fwd_b_o !== 2'b01) begin n_fail++; $display("FAIL lu_dep_fwd_b: got %b want 01", fwd_b_o); end
      n_checks++; if (fwd_a_o !== 2'b00) begin n_fail++; $display("FAIL lu_dep_fwd_a: got %b want 00", fwd_a_o); end
      n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d want %0d", lu_cnt_o, exp_cnt); end
      drain();
   endtask

   task automatic test_stall_flush();
      id(1, 0, 0, 3, 1, 0); tick();
      id(1, 3, 0, 7, 1, 0); tick();
      id(1, 0, 0, 0, 0, 0);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (fwd_a_o !== 2'b10) begin n_fail++; $display("FAIL stall_fwd_hold[%0d]: got %b want 10", i, fwd_a_o); end
      end
      stall_i = 1'b0;
      drain();
      id(1, 1, 0, 6, 1, 1); tick();
      id(1, 6, 0, 12, 1, 0);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL stall_cnt_hold[%0d]: got %0d want %0d", i, lu_cnt_o, exp_cnt); end
         n_checks++; if (lu_stall_o !== 1'b1) begin n_fail++; $display("FAIL stall_lu_level[%0d]: got %b want 1", i, lu_stall_o); end
      end
      stall_i = 1'b0;
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL stall_release_cnt: got %0d want %0d", lu_cnt_o, exp_cnt); end
      drain();
      id(1, 0, 0, 3, 1, 0); tick();
      id(1, 3, 0, 7, 1, 0); flush_i = 1'b1; tick();
      flush_i = 1'b0; id(0, 0, 0, 0, 0, 0);
      n_checks++; if (fwd_a_o !== 2'b00) begin n_fail++; $display("FAIL flush_fwd_a: got %b want 00", fwd_a_o); end
      drain();
      id(1, 1, 0, 5, 1, 1); tick();
      id(1, 0, 5, 13, 1, 0); flush_i = 1'b1; tick();
      flush_i = 1'b0; id(0, 0, 0, 0, 0, 0);
      n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL flush_no_count: got %0d want %0d", lu_cnt_o, exp_cnt); end
      drain();
      id(1, 0, 0, 3, 1, 0); tick();
      id(1, 3, 0, 7, 1, 0); flush_i = 1'b1; stall_i = 1'b1; tick();
      flush_i = 1'b0; stall_i = 1'b0; tick();
      id(0, 0, 0, 0, 0, 0);
      n_checks++; if (fwd_a_o !== 2'b10) begin n_fail++; $display("FAIL stall_flush_lost: got %b want 10", fwd_a_o); end
      drain();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         id(1, 1, 2, 5, 1, 1); tick();
         id(1, 5, 0, 0, 0, 0);
         n_checks++; if (lu_stall_o !== 1'b1) begin n_fail++; $display("FAIL sat_lu_raise[%0d]: got %b want 1", i, lu_stall_o); end
         tick();
         if (exp_cnt < 15) exp_cnt = exp_cnt + 1;
      end
      n_checks++; if (lu_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d want 15", lu_cnt_o); end
      n_checks++; if (lu_cnt_o !== 4'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt_model: got %0d want %0d", lu_cnt_o, exp_cnt); end
      drain();
      n_checks++; if (lu_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", lu_cnt_o); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_double_producer();
      test_load_use();
      test_stall_flush();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
